// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with 2-bit saturating counters,
// combinational fetch lookup, execute-stage resolution/update, and
// saturating statistics counters for branches and mispredicts.
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] NextPCF,
  input  logic        ValidE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        JalrE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] TargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [15:0] BranchCnt,
  output logic [15:0] MispredCnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] validq;
  logic [ENTRIES-1:0] jmpq;
  logic [TAG_W-1:0]   tagq    [ENTRIES];
  logic [31:0]        targetq [ENTRIES];
  logic [1:0]         ctrq    [ENTRIES];

  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxE;
  logic [TAG_W-1:0] tagF;
  logic [TAG_W-1:0] tagE;
  logic             hitF;
  logic             hitE;
  logic             doUpdate;
  logic             unusedPcBits;

  assign idxF = PCF[2 +: IDX_W];
  assign tagF = PCF[31:2+IDX_W];
  assign idxE = PCE[2 +: IDX_W];
  assign tagE = PCE[31:2+IDX_W];
  assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

  // Fetch lookup reads registered table state, so a same-cycle update is seen only next cycle
  always_comb begin
    hitF       = validq[idxF] && (tagq[idxF] == tagF);
    PredTakenF = hitF && (jmpq[idxF] || ctrq[idxF][1]);
    NextPCF    = PredTakenF ? targetq[idxF] : PCF + 32'd4;
  end

  // Execute-stage resolution: flush request and corrected fetch address
  always_comb begin
    hitE        = validq[idxE] && (tagq[idxE] == tagE);
    doUpdate    = ValidE && (BranchE || JumpE) && !JalrE;
    MispredictE = ValidE && ((TakenE != PredTakenE) ||
                             (TakenE && PredTakenE && (PredTargetE != TargetE)));
    RedirectPCE = TakenE ? TargetE : PCE + 32'd4;
  end

  // Table update: train on hit, allocate only on a taken miss; JALR never touches the table
  always_ff @(posedge clk) begin
    if (rst) begin
      validq <= '0;
      jmpq   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagq[i]    <= '0;
        targetq[i] <= '0;
        ctrq[i]    <= 2'b01;
      end
    end else if (doUpdate) begin
      if (hitE) begin
        if (JumpE) begin
          targetq[idxE] <= TargetE;
        end else begin
          if (TakenE) begin
            targetq[idxE] <= TargetE;
            if (ctrq[idxE] != 2'b11) ctrq[idxE] <= ctrq[idxE] + 2'b01;
          end else begin
            if (ctrq[idxE] != 2'b00) ctrq[idxE] <= ctrq[idxE] - 2'b01;
          end
        end
      end else if (TakenE) begin
        validq[idxE]  <= 1'b1;
        tagq[idxE]    <= tagE;
        targetq[idxE] <= TargetE;
        jmpq[idxE]    <= JumpE;
        ctrq[idxE]    <= 2'b10;
      end
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      BranchCnt  <= '0;
      MispredCnt <= '0;
    end else begin
      if (ValidE && BranchE && (BranchCnt != 16'hFFFF)) BranchCnt <= BranchCnt + 16'd1;
      if (MispredictE && (MispredCnt != 16'hFFFF)) MispredCnt <= MispredCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with hand-computed expectations.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] NextPCF;
  logic        ValidE;
  logic        BranchE;
  logic        JumpE;
  logic        JalrE;
  logic        TakenE;
  logic [31:0] PCE;
  logic [31:0] TargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [15:0] BranchCnt;
  logic [15:0] MispredCnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .NextPCF(NextPCF),
    .ValidE(ValidE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE), .PredTakenE(PredTakenE),
    .PredTargetE(PredTargetE), .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1-2 time units after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic br, input logic jp, input logic jr,
                               input logic tk, input logic [31:0] pce, input logic [31:0] tgt,
                               input logic ptk, input logic [31:0] ptgt);
    ValidE = v; BranchE = br; JumpE = jp; JalrE = jr; TakenE = tk;
    PCE = pce; TargetE = tgt; PredTakenE = ptk; PredTargetE = ptgt;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFetch(input string tag, input logic [31:0] pc, input logic expTaken,
                            input logic [31:0] expNext);
    PCF = pc;
    #1;
    checkOutput({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, expTaken});
    checkOutput({tag, "_next"}, NextPCF, expNext);
  endtask

  initial begin
    rst = 1'b1;
    PCF = 32'h100;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    checkFetch("rst_fetch", 32'h100, 1'b0, 32'h104);
    checkOutput("rst_brcnt", {16'd0, BranchCnt}, 32'd0);
    checkOutput("rst_mpcnt", {16'd0, MispredCnt}, 32'd0);

    // Taken branch miss: allocate, ctr=10; lookup in same cycle sees old contents
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    checkOutput("alloc_mispred", {31'd0, MispredictE}, 32'd1);
    checkOutput("alloc_redirect", RedirectPCE, 32'h80);
    checkFetch("same_cycle_old", 32'h100, 1'b0, 32'h104);
    tick();
    idle();
    checkFetch("alloc_fetch", 32'h100, 1'b1, 32'h80);
    checkOutput("alloc_mpcnt", {16'd0, MispredCnt}, 32'd1);
    checkOutput("alloc_brcnt", {16'd0, BranchCnt}, 32'd1);

    // Not-taken twice: ctr 10 -> 01 -> 00
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    checkOutput("nt1_mispred", {31'd0, MispredictE}, 32'd1);
    checkOutput("nt1_redirect", RedirectPCE, 32'h104);
    tick();
    idle();
    checkFetch("nt1_fetch", 32'h100, 1'b0, 32'h104);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
    checkOutput("nt2_mispred", {31'd0, MispredictE}, 32'd1);
    checkOutput("nt2_redirect", RedirectPCE, 32'h104);
    tick();
    idle();
    checkFetch("nt2_fetch", 32'h100, 1'b0, 32'h104);
    // One taken from strong-NT reaches only weak-NT
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0);
    tick();
    idle();
    checkFetch("ctr_sat_low", 32'h100, 1'b0, 32'h104);
    checkOutput("nt_brcnt", {16'd0, BranchCnt}, 32'd4);
    checkOutput("nt_mpcnt", {16'd0, MispredCnt}, 32'd4);

    // Aliasing jump at 0x1100 evicts the 0x100 entry
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1100, 32'h40, 1'b0, 32'h0);
    checkOutput("alias_mispred", {31'd0, MispredictE}, 32'd1);
    tick();
    idle();
    checkFetch("alias_old", 32'h100, 1'b0, 32'h104);
    checkFetch("alias_new", 32'h1100, 1'b1, 32'h40);
    checkOutput("alias_brcnt", {16'd0, BranchCnt}, 32'd4);

    // Correct target prediction is not a mispredict; wrong target is, and retrains target
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1100, 32'h40, 1'b1, 32'h40);
    checkOutput("tgt_ok_mispred", {31'd0, MispredictE}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1100, 32'h44, 1'b1, 32'h40);
    checkOutput("tgt_bad_mispred", {31'd0, MispredictE}, 32'd1);
    checkOutput("tgt_bad_redirect", RedirectPCE, 32'h44);
    tick();
    idle();
    checkFetch("tgt_retrain", 32'h1100, 1'b1, 32'h44);
    checkOutput("tgt_mpcnt", {16'd0, MispredCnt}, 32'd6);

    // JALR: mispredict but no allocation
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h200, 1'b0, 32'h0);
    checkOutput("jalr_mispred", {31'd0, MispredictE}, 32'd1);
    checkOutput("jalr_redirect", RedirectPCE, 32'h200);
    tick();
    idle();
    checkFetch("jalr_noalloc", 32'h200, 1'b0, 32'h204);
    checkOutput("jalr_mpcnt", {16'd0, MispredCnt}, 32'd7);

    // Bubble: no mispredict, no state change
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'h500, 1'b0, 32'h0);
    checkOutput("bubble_mispred", {31'd0, MispredictE}, 32'd0);
    tick();
    idle();
    checkFetch("bubble_noalloc", 32'h300, 1'b0, 32'h304);
    checkOutput("bubble_brcnt", {16'd0, BranchCnt}, 32'd4);
    checkOutput("bubble_mpcnt", {16'd0, MispredCnt}, 32'd7);

    // Mispredict counter saturation (no table-updating class set)
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 32'h700, 1'b0, 32'h0);
    for (int i = 0; i < 65540; i++) tick();
    checkOutput("mp_saturate", {16'd0, MispredCnt}, 32'h0000FFFF);
    checkFetch("sat_keep_entry", 32'h1100, 1'b1, 32'h44);

    // Reset mid-stream dominates concurrent update and wipes history
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1100, 32'h88, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    checkFetch("midrst_fetch", 32'h1100, 1'b0, 32'h1104);
    checkOutput("midrst_brcnt", {16'd0, BranchCnt}, 32'd0);
    checkOutput("midrst_mpcnt", {16'd0, MispredCnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, number of direct-mapped BTB entries; index = PC[5:2], tag = PC[31:6].
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port PCF, input, 32, fetch-stage PC.
REQ-005 SHALL have port PredTakenF, output, 1, fetch prediction taken.
REQ-006 SHALL have port NextPCF, output, 32, predicted next fetch PC.
REQ-007 SHALL have port ValidE, input, 1, execute-stage instruction is real, not a bubble.
REQ-008 SHALL have ports BranchE, JumpE and JalrE, each input, 1, execute-stage control-transfer class.
REQ-009 SHALL have port TakenE, input, 1, resolved outcome; 1 when branch condition is met, or for JumpE or JalrE.
REQ-010 SHALL have ports PCE and TargetE, each input, 32, execute-stage PC and resolved target.
REQ-011 SHALL have ports PredTakenE, input, 1, and PredTargetE, input, 32, carrying the prediction made for this instruction at fetch.
REQ-012 SHALL have port MispredictE, output, 1, pipeline-flush request.
REQ-013 SHALL have port RedirectPCE, output, 32, corrected fetch PC.
REQ-014 SHALL have ports BranchCnt and MispredCnt, each output, 16, statistics counters.

Function
REQ-015 Each entry SHALL hold valid, tag[25:0], target[31:0], jmp and ctr[1:0]; ctr is a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-016 Lookup SHALL be combinational: hit = valid & tag==PCF[31:6]; PredTakenF = hit & (jmp | ctr[1]).
REQ-017 NextPCF SHALL equal target when PredTakenF=1, else PCF+4 (mod 2^32).
REQ-018 Update SHALL occur only when ValidE & (BranchE | JumpE) & ~JalrE; JALR SHALL never be allocated or updated.
REQ-019 Update on hit, branch: ctr increments if TakenE, decrements otherwise, saturating at 11/00; target <= TargetE when TakenE.
REQ-020 Update on miss with TakenE=1: entry overwritten with valid=1, tag=PCE[31:6], target=TargetE, jmp=JumpE, ctr=10; this evicts any prior occupant.
REQ-021 Update on miss with TakenE=0 SHALL change no entry.
REQ-022 Update on hit, jump: target <= TargetE; ctr unchanged.
REQ-023 MispredictE SHALL equal ValidE & ((TakenE != PredTakenE) | (TakenE & PredTakenE & PredTargetE != TargetE)); it is combinational and has no latency.
REQ-024 RedirectPCE SHALL equal TargetE when TakenE=1, else PCE+4.
REQ-025 On a same-cycle lookup and update to the same index, the lookup SHALL return pre-update contents; the new value is visible from the next cycle.
REQ-026 BranchCnt SHALL increment by 1 when ValidE & BranchE; it saturates at 16'hFFFF.
REQ-027 MispredCnt SHALL increment by 1 when MispredictE=1; it saturates at 16'hFFFF.
REQ-028 When ValidE=0, no table or counter state SHALL change and MispredictE=0.

Reset
REQ-029 While rst=1 at a clock edge, all valid bits SHALL be cleared, all ctr set to 01, jmp and target set to 0, and BranchCnt and MispredCnt set to 0.
REQ-030 Reset SHALL dominate any concurrent update; after reset, PredTakenF=0 and NextPCF=PCF+4 for every PCF.
REQ-031 Reset asserted mid-operation SHALL discard all learned history within one cycle.

Verification
REQ-032 After reset, with PCF=0x100: PredTakenF=0, NextPCF=0x104, and both counters read 0.
REQ-033 Taken branch resolved at PCE=0x100, TargetE=0x80, PredTakenE=0: MispredictE=1 and RedirectPCE=0x80. Next cycle, PCF=0x100 gives PredTakenF=1 and NextPCF=0x80; MispredCnt=1.
REQ-034 Same branch resolved not-taken twice:
- ctr goes 10 -> 01 -> 00.
- PredTakenF for PCF=0x100 becomes 0 after the first update.
- RedirectPCE=0x104 on each mispredict.
REQ-035 Aliasing: PCE=0x1100, same index as 0x100, with a taken jump to 0x40 evicts the entry. PCF=0x100 then gives PredTakenF=0; PCF=0x1100 gives PredTakenF=1 and NextPCF=0x40.
REQ-036 JalrE=1, TakenE=1, TargetE=0x200, PredTakenE=0: MispredictE=1, RedirectPCE=0x200, and no table entry is allocated.
REQ-037 Same-cycle update and lookup at the same index returns the old prediction. Drive 65540 mispredicts: MispredCnt holds 16'hFFFF. Assert rst mid-stream: all counters and predictions clear next cycle.
